soc_system_pio_out: RTL and testbench
=====================================

Name: soc_system_pio_out

Overview:
- Avalon-MM slave output PIO; the write-side counterpart of the team's read-only input PIO on the HPS lightweight bridge.
- Drives a registered output bus (LEDs, sensor triggers, CNN-accelerator control strobes) with these host-visible controls:
  - full-word write and readback;
  - atomic bit set and bit clear;
  - timed one-shot pulse bits that clear themselves after a programmable cycle count.

Parameters:
- DATA_WIDTH, 32, width of out_port and of the DATA, OUTSET, OUTCLEAR and PULSE registers (1..32).
- RESET_VALUE, 0, value loaded into the DATA register at reset.
- PULSE_CNT_W, 16, width of the PULSE_LEN register and of the pulse down-counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is valid only when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes; present only when PIO_OUT_BYTEENABLE_EN is defined.
- readdata  out  32  registered read data.
- out_port  out  DATA_WIDTH  registered output, equal to data_reg | pulse_mask.

Behaviour:
- Reset (asynchronous):
  - data_reg=RESET_VALUE; pulse_mask=0; pulse_len=1; cnt=0; state=IDLE; readdata=0.
  - out_port therefore equals RESET_VALUE.
- Address map:
  - 0 DATA: read/write.
  - 1 PULSE_LEN: read/write, bits [PULSE_CNT_W-1:0].
  - 2 PULSE: write ORs bits into pulse_mask; read returns pulse_mask.
  - 3 STATUS: read-only; bit31=active; bits[PULSE_CNT_W-1:0]=cnt.
  - 4 OUTSET: write-only; data_reg |= writedata.
  - 5 OUTCLEAR: write-only; data_reg &= ~writedata.
  - 6, 7: read 0; writes ignored.
- Write-only registers (OUTSET, OUTCLEAR) read as 0.
- Unused upper bits (above DATA_WIDTH, or above PULSE_CNT_W for PULSE_LEN) are ignored on write and read as 0.
- Read path:
  - readdata is updated every clk edge from the address mux, with no read strobe.
  - Read latency is 1 cycle; the slave has no waitrequest.
- Write path:
  - Register updates take effect on the clk edge of a valid write.
  - out_port reflects the new value in the next cycle.
- Pulse FSM, IDLE -> ACTIVE:
  - Trigger: write to PULSE with a nonzero mask.
  - Actions: pulse_mask |= wdata; cnt = max(pulse_len, 1).
- Pulse FSM, ACTIVE:
  - cnt decrements by 1 per cycle.
  - When cnt==1, the edge clears pulse_mask and cnt and returns to IDLE.
  - Pulse bits are therefore visible on out_port for exactly max(pulse_len,1) cycles.
- Pulse FSM, write to PULSE while ACTIVE:
  - New bits are ORed into pulse_mask.
  - cnt reloads from pulse_len, so all pulse bits are extended.
  - The reload takes priority over the decrement in the same cycle.
- A write of 0 to PULSE has no effect.
- A write to PULSE_LEN while ACTIVE does not change the current cnt; it applies to the next trigger.
- pulse_len=0 is treated as 1.
- OUTSET and OUTCLEAR affect data_reg only, never pulse_mask.
- Reset mid-pulse aborts the pulse immediately (asynchronous): pulse_mask=0 and state=IDLE.

Optional Feature:
- PIO_OUT_BYTEENABLE_EN
- Defined:
  - byteenable port present.
  - Writes to DATA, OUTSET, OUTCLEAR, PULSE and PULSE_LEN affect only bytes whose byteenable bit is 1.
  - For OUTSET, OUTCLEAR and PULSE, disabled lanes contribute zero bits.
- Undefined:
  - Port absent; all writes are full-word.

Decomposition:
- Shared package soc_pio_pkg holds:
  - address constants: PIO_ADDR_DATA=0, PIO_ADDR_PULSE_LEN=1, PIO_ADDR_PULSE=2, PIO_ADDR_STATUS=3, PIO_ADDR_OUTSET=4, PIO_ADDR_OUTCLEAR=5;
  - STATUS_ACTIVE_BIT=31;
  - pulse state enum {IDLE, ACTIVE}.
- One sub-module, soc_pio_pulse_timer:
  - Contains the FSM, down-counter and pulse_mask.
  - Inputs: trigger, trigger mask, pulse_len.
  - Outputs: pulse_mask, active, cnt.
- The top level holds the register decode, data_reg and the read mux.

Test Plan:
- Reset with RESET_VALUE=32'h0000_00A5 -> out_port=0xA5, readdata=0; after reset, read addr0 -> 0xA5 one cycle later.
- Write DATA=0x0F, then OUTSET=0xF0, then OUTCLEAR=0x03 -> out_port=0x0F, 0xFF, 0xFC on successive cycles after each write; reads of addr4 and addr5 return 0.
- PULSE_LEN=5, write PULSE=0x100 with DATA=0 -> out_port bit8 high for exactly 5 cycles; STATUS reads 0x8000_0005 down to 0x8000_0001, then 0.
- Retrigger at cycle 3 of a 5-cycle pulse with PULSE=0x200 -> bits 8 and 9 high; both drop together 5 cycles after the retrigger.
- PULSE_LEN=0, PULSE=0x1 -> exactly one cycle high. Assert reset_n=0 mid-pulse -> out_port returns to RESET_VALUE immediately.
- With PIO_OUT_BYTEENABLE_EN: DATA=0, write DATA=0xAABBCCDD with byteenable=4'b0101 -> readback 0x00BB00DD. Without the macro, the same write -> 0xAABBCCDD.

Source files
------------

// File: rtl/soc_system_pio_out_pkg.sv
// Shared definitions for the output PIO slice: register map, status bit
// position, pulse FSM states and a byte-lane mask helper.
package soc_pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA      = 3'd0;
  localparam logic [2:0] PIO_ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] PIO_ADDR_PULSE     = 3'd2;
  localparam logic [2:0] PIO_ADDR_STATUS    = 3'd3;
  localparam logic [2:0] PIO_ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] PIO_ADDR_OUTCLEAR  = 3'd5;

  localparam int STATUS_ACTIVE_BIT = 31;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

  // Expands a 4-bit byteenable into a 32-bit bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/soc_system_pio_out_if.sv
// Avalon-MM slave bus bundle for the output PIO; byteenable exists only
// when PIO_OUT_BYTEENABLE_EN is defined.
interface soc_system_pio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
`ifdef PIO_OUT_BYTEENABLE_EN
  logic [3:0]  byteenable;
`endif
  logic [31:0] readdata;

`ifdef PIO_OUT_BYTEENABLE_EN
  modport master (output address, chipselect, write_n, writedata, byteenable,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, writedata, byteenable,
                  output readdata);
`else
  modport master (output address, chipselect, write_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata);
`endif
endinterface

// File: rtl/soc_pio_pulse_timer.sv
// One-shot pulse generator: holds pulse_mask for max(pulse_len,1) cycles
// after a trigger; a retrigger ORs in new bits and restarts the count.
module soc_pio_pulse_timer
  import soc_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PULSE_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trig_i,
  input  logic [DATA_WIDTH-1:0]  trig_mask_i,
  input  logic [PULSE_CNT_W-1:0] pulse_len_i,
  output logic [DATA_WIDTH-1:0]  pulse_mask_o,
  output logic                   active_o,
  output logic [PULSE_CNT_W-1:0] cnt_o
);

  pulse_state_e           state_q;
  logic [DATA_WIDTH-1:0]  mask_q;
  logic [PULSE_CNT_W-1:0] cnt_q;
  logic [PULSE_CNT_W-1:0] load_val;
  logic                   trig;

  assign trig     = trig_i && (|trig_mask_i);
  assign load_val = (pulse_len_i == '0) ? PULSE_CNT_W'(1) : pulse_len_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig) begin
            mask_q  <= mask_q | trig_mask_i;
            cnt_q   <= load_val;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A retrigger wins over the terminal-count clear.
          if (trig) begin
            mask_q <= mask_q | trig_mask_i;
            cnt_q  <= load_val;
          end else if (cnt_q == PULSE_CNT_W'(1)) begin
            mask_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - PULSE_CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          mask_q  <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pulse_mask_o = mask_q;
  assign active_o     = (state_q == ACTIVE);
  assign cnt_o        = cnt_q;

endmodule

// File: rtl/soc_system_pio_out.sv
// Avalon-MM output PIO with write/readback, atomic set/clear and timed pulse
// bits. Optional per-byte write masking under PIO_OUT_BYTEENABLE_EN.
module soc_system_pio_out
  import soc_pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          PULSE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  soc_system_pio_out_if.slave   bus,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                   wr_en;
  logic [31:0]            lane_mask;
  logic [31:0]            wd_m;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [PULSE_CNT_W-1:0] len_q, len_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   trig;
  logic [DATA_WIDTH-1:0]  pulse_mask;
  logic                   active;
  logic [PULSE_CNT_W-1:0] cnt;

  assign wr_en = bus.chipselect && !bus.write_n;

`ifdef PIO_OUT_BYTEENABLE_EN
  assign lane_mask = be_to_mask(bus.byteenable);
`else
  assign lane_mask = '1;
`endif

  // Disabled lanes contribute zero bits to every write source.
  assign wd_m = bus.writedata & lane_mask;

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (wr_en) begin
      case (bus.address)
        PIO_ADDR_DATA:
          data_d = (data_q & ~lane_mask[DATA_WIDTH-1:0]) | wd_m[DATA_WIDTH-1:0];
        PIO_ADDR_OUTSET:
          data_d = data_q | wd_m[DATA_WIDTH-1:0];
        PIO_ADDR_OUTCLEAR:
          data_d = data_q & ~wd_m[DATA_WIDTH-1:0];
        PIO_ADDR_PULSE_LEN:
          len_d = (len_q & ~lane_mask[PULSE_CNT_W-1:0]) | wd_m[PULSE_CNT_W-1:0];
        default: ;
      endcase
    end
  end

  assign trig = wr_en && (bus.address == PIO_ADDR_PULSE);

  soc_pio_pulse_timer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PULSE_CNT_W (PULSE_CNT_W)
  ) u_pulse (
    .clk          (clk),
    .reset_n      (reset_n),
    .trig_i       (trig),
    .trig_mask_i  (wd_m[DATA_WIDTH-1:0]),
    .pulse_len_i  (len_q),
    .pulse_mask_o (pulse_mask),
    .active_o     (active),
    .cnt_o        (cnt)
  );

  // Read mux is sampled every cycle; no read strobe is needed.
  always_comb begin
    rdata_d = '0;
    case (bus.address)
      PIO_ADDR_DATA:      rdata_d[DATA_WIDTH-1:0]  = data_q;
      PIO_ADDR_PULSE_LEN: rdata_d[PULSE_CNT_W-1:0] = len_q;
      PIO_ADDR_PULSE:     rdata_d[DATA_WIDTH-1:0]  = pulse_mask;
      PIO_ADDR_STATUS: begin
        rdata_d[PULSE_CNT_W-1:0]    = cnt;
        rdata_d[STATUS_ACTIVE_BIT] = active;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE[DATA_WIDTH-1:0];
      len_q   <= PULSE_CNT_W'(1);
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      len_q   <= len_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign out_port     = data_q | pulse_mask;

endmodule

// File: tb/tb_soc_system_pio_out.sv
// Directed bench for soc_system_pio_out: register table plus pulse,
// retrigger, zero-length, reset-abort and byte-lane sequences.
module tb_soc_system_pio_out;
  import soc_pio_pkg::*;

  localparam logic [31:0] RV = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] out_port;
  logic [31:0] rv;
  int          total = 0;
  int          bad = 0;

  soc_system_pio_out_if bus();

  soc_system_pio_out #(
    .DATA_WIDTH  (32),
    .RESET_VALUE (RV),
    .PULSE_CNT_W (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
`ifdef PIO_OUT_BYTEENABLE_EN
    bus.byteenable = be;
`else
    if (be != 4'hF) bus.chipselect = 1'b1;
`endif
  endtask

  task automatic idle_bus();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Write issued at a negedge, captured at the next posedge, bus idle afterwards.
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    drive_wr(a, d, be);
    @(negedge clk);
    idle_bus();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    v = bus.readdata;
  endtask

  initial begin
    vecs[0] = '{"data_wr",      PIO_ADDR_DATA,      32'h0000_000F, PIO_ADDR_DATA,      32'h0F, 32'h0F};
    vecs[1] = '{"outset",       PIO_ADDR_OUTSET,    32'h0000_00F0, PIO_ADDR_OUTSET,    32'hFF, 32'h0};
    vecs[2] = '{"outclear",     PIO_ADDR_OUTCLEAR,  32'h0000_0003, PIO_ADDR_OUTCLEAR,  32'hFC, 32'h0};
    vecs[3] = '{"plen_trunc",   PIO_ADDR_PULSE_LEN, 32'h0001_2345, PIO_ADDR_PULSE_LEN, 32'hFC, 32'h2345};
    vecs[4] = '{"addr6_ignore", 3'd6,               32'hFFFF_FFFF, 3'd6,               32'hFC, 32'h0};
    vecs[5] = '{"addr7_ignore", 3'd7,               32'hFFFF_FFFF, PIO_ADDR_DATA,      32'hFC, 32'hFC};
    vecs[6] = '{"pulse_zero",   PIO_ADDR_PULSE,     32'h0,         PIO_ADDR_STATUS,    32'hFC, 32'h0};
    vecs[7] = '{"plen5",        PIO_ADDR_PULSE_LEN, 32'h5,         PIO_ADDR_PULSE_LEN, 32'hFC, 32'h5};
    vecs[8] = '{"data_zero",    PIO_ADDR_DATA,      32'h0,         PIO_ADDR_DATA,      32'h0,  32'h0};

    bus.address = '0; bus.writedata = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
`ifdef PIO_OUT_BYTEENABLE_EN
    bus.byteenable = 4'hF;
`endif

    // Reset state
    #12;
    chk("rst_out", out_port, RV);
    chk("rst_rd", bus.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(PIO_ADDR_DATA, rv);
    chk("rst_data_rd", rv, RV);
    rd(PIO_ADDR_PULSE_LEN, rv);
    chk("rst_plen_rd", rv, 32'h1);

    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wdata, 4'hF);
      chk({vecs[i].name, "_out"}, out_port, vecs[i].exp_out);
      rd(vecs[i].raddr, rv);
      chk({vecs[i].name, "_rd"}, rv, vecs[i].exp_rd);
    end

    // 5-cycle pulse with STATUS countdown
    bus.address = PIO_ADDR_PULSE;
    @(negedge clk);
    drive_wr(PIO_ADDR_PULSE, 32'h100, 4'hF);
    @(negedge clk);
    idle_bus();
    bus.address = PIO_ADDR_STATUS;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pulse_hi%0d", i), out_port, 32'h100);
      @(negedge clk);
      chk($sformatf("status%0d", i), bus.readdata, 32'h8000_0000 | (5 - i));
    end
    chk("pulse_lo", out_port, 32'h0);
    @(negedge clk);
    chk("status_idle", bus.readdata, 32'h0);

    // Retrigger in the third cycle of the pulse
    wr(PIO_ADDR_PULSE, 32'h100, 4'hF);
    chk("rt_c1", out_port, 32'h100);
    @(negedge clk);
    chk("rt_c2", out_port, 32'h100);
    drive_wr(PIO_ADDR_PULSE, 32'h200, 4'hF);
    @(negedge clk);
    idle_bus();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rt_hi%0d", i), out_port, 32'h300);
      @(negedge clk);
    end
    chk("rt_lo", out_port, 32'h0);

    // Zero length behaves as one cycle
    wr(PIO_ADDR_PULSE_LEN, 32'h0, 4'hF);
    wr(PIO_ADDR_PULSE, 32'h1, 4'hF);
    chk("len0_hi", out_port, 32'h1);
    @(negedge clk);
    chk("len0_lo", out_port, 32'h0);

    // OUTCLEAR leaves pulse bits alone; reset aborts mid-pulse
    wr(PIO_ADDR_PULSE_LEN, 32'h5, 4'hF);
    wr(PIO_ADDR_DATA, 32'h0F, 4'hF);
    wr(PIO_ADDR_PULSE, 32'h100, 4'hF);
    wr(PIO_ADDR_OUTCLEAR, 32'hFFFF_FFFF, 4'hF);
    chk("clr_keeps_pulse", out_port, 32'h100);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_out", out_port, RV);
    chk("abort_rd", bus.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(PIO_ADDR_STATUS, rv);
    chk("abort_status", rv, 32'h0);
    rd(PIO_ADDR_PULSE, rv);
    chk("abort_mask", rv, 32'h0);

    // Byte-lane masking
    wr(PIO_ADDR_DATA, 32'h0, 4'hF);
    wr(PIO_ADDR_DATA, 32'hAABB_CCDD, 4'b0101);
    rd(PIO_ADDR_DATA, rv);
`ifdef PIO_OUT_BYTEENABLE_EN
    chk("be_data", rv, 32'h00BB_00DD);
    wr(PIO_ADDR_OUTSET, 32'hFFFF_FFFF, 4'b0010);
    chk("be_outset", out_port, 32'h00BB_FFDD);
`else
    chk("be_data", rv, 32'hAABB_CCDD);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
